// File: rtl/wb_commit.sv
// Writeback/commit stage: GPR write port, machine-mode CSRs, and trap/mret redirect FSM.
// Optional 64-bit mcycle counter is built when WB_MCYCLE_EN is defined.
`timescale 1ns/1ps
module wb_commit #(
    parameter logic [31:0] RESET_PC_VEC = 32'h0000_0000,
    parameter logic [31:0] IRQ_CAUSE    = 32'h8000_000B,
    parameter logic [31:0] EXC_CAUSE    = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        wb_wr_reg,
    input  logic [4:0]  wb_wr_regindex,
    input  logic [31:0] wb_wr_wdata,
    input  logic [31:0] wb_pc,
    input  logic        wb_exp,
    input  logic        wb_wr_csrreg,
    input  logic [11:0] wb_wr_csrindex,
    input  logic [31:0] wb_wr_csrwdata,
    input  logic        wb_mret,
    input  logic        ext_irq,
    input  logic [11:0] csr_rindex,
    output logic [31:0] csr_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        interrupt,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
`ifdef WB_MCYCLE_EN
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
`endif

    typedef enum logic [1:0] {RUN, TRAP, RET} state_t;

    state_t      state_q, state_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        interrupt_q, interrupt_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic is_run, take_exc, take_irq, take_trap, do_mret, do_csr;

    // Event arbitration; WB inputs are bubbles outside RUN.
    always_comb begin
        is_run    = (state_q == RUN);
        take_exc  = is_run & wb_exp;
        take_irq  = is_run & ~wb_exp & ext_irq & mie_q;
        take_trap = take_exc | take_irq;
        do_mret   = is_run & ~take_trap & wb_mret;
        do_csr    = is_run & ~take_trap & ~wb_mret & wb_wr_csrreg;
    end

    assign rf_we    = is_run & wb_wr_reg & (wb_wr_regindex != 5'd0) & ~take_trap;
    assign rf_waddr = wb_wr_regindex;
    assign rf_wdata = wb_wr_wdata;

    always_comb begin
        state_d          = RUN;
        mie_d            = mie_q;
        mpie_d           = mpie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        interrupt_d      = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        case (state_q)
            RUN: begin
                if (take_trap) begin
                    state_d          = TRAP;
                    mepc_d           = wb_pc;
                    mcause_d         = take_exc ? EXC_CAUSE : IRQ_CAUSE;
                    mpie_d           = mie_q;
                    mie_d            = 1'b0;
                    interrupt_d      = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = mtvec_q;
                end else if (do_mret) begin
                    state_d          = RET;
                    mie_d            = mpie_q;
                    mpie_d           = 1'b1;
                    interrupt_d      = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = mepc_q;
                end else if (do_csr) begin
                    case (wb_wr_csrindex)
                        CSR_MSTATUS: begin
                            mie_d  = wb_wr_csrwdata[3];
                            mpie_d = wb_wr_csrwdata[7];
                        end
                        CSR_MTVEC:    mtvec_d    = {wb_wr_csrwdata[31:2], 2'b00};
                        CSR_MSCRATCH: mscratch_d = wb_wr_csrwdata;
                        CSR_MEPC:     mepc_d     = {wb_wr_csrwdata[31:2], 2'b00};
                        CSR_MCAUSE:   mcause_d   = wb_wr_csrwdata;
                        default: ;
                    endcase
                end
            end
            TRAP:    state_d = RUN;
            RET:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state_q          <= RUN;
            mie_q            <= 1'b0;
            mpie_q           <= 1'b0;
            mtvec_q          <= RESET_PC_VEC;
            mscratch_q       <= 32'h0;
            mepc_q           <= 32'h0;
            mcause_q         <= 32'h0;
            interrupt_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
        end else begin
            state_q          <= state_d;
            mie_q            <= mie_d;
            mpie_q           <= mpie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            interrupt_q      <= interrupt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

`ifdef WB_MCYCLE_EN
    logic [63:0] mcycle_q, mcycle_d;

    // A CSR write to either half replaces the increment for that cycle.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (do_csr && wb_wr_csrindex == CSR_MCYCLE)
            mcycle_d = {mcycle_q[63:32], wb_wr_csrwdata};
        else if (do_csr && wb_wr_csrindex == CSR_MCYCLEH)
            mcycle_d = {wb_wr_csrwdata, mcycle_q[31:0]};
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) mcycle_q <= 64'h0;
        else        mcycle_q <= mcycle_d;
    end
`endif

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_rindex)
            CSR_MSTATUS:  csr_rdata = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
`ifdef WB_MCYCLE_EN
            CSR_MCYCLE:   csr_rdata = mcycle_q[31:0];
            CSR_MCYCLEH:  csr_rdata = mcycle_q[63:32];
`endif
            default:      csr_rdata = 32'h0;
        endcase
    end

    assign interrupt      = interrupt_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: redirect scoreboard plus GPR/CSR spot checks.
`timescale 1ns/1ps
module tb_wb_commit;
    logic        clk = 1'b0;
    logic        cpurst;
    logic        wb_wr_reg;
    logic [4:0]  wb_wr_regindex;
    logic [31:0] wb_wr_wdata;
    logic [31:0] wb_pc;
    logic        wb_exp;
    logic        wb_wr_csrreg;
    logic [11:0] wb_wr_csrindex;
    logic [31:0] wb_wr_csrwdata;
    logic        wb_mret;
    logic        ext_irq;
    logic [11:0] csr_rindex;
    logic [31:0] csr_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        interrupt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_redir_q[$];

    wb_commit dut (
        .clk(clk), .cpurst(cpurst),
        .wb_wr_reg(wb_wr_reg), .wb_wr_regindex(wb_wr_regindex), .wb_wr_wdata(wb_wr_wdata),
        .wb_pc(wb_pc), .wb_exp(wb_exp),
        .wb_wr_csrreg(wb_wr_csrreg), .wb_wr_csrindex(wb_wr_csrindex), .wb_wr_csrwdata(wb_wr_csrwdata),
        .wb_mret(wb_mret), .ext_irq(ext_irq),
        .csr_rindex(csr_rindex), .csr_rdata(csr_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .interrupt(interrupt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_check(input string tag, input logic [11:0] idx, input logic [31:0] exp);
        csr_rindex = idx;
        #0.5;
        check(tag, csr_rdata, exp);
    endtask

    task automatic csr_write(input logic [11:0] idx, input logic [31:0] data);
        wb_wr_csrreg   = 1'b1;
        wb_wr_csrindex = idx;
        wb_wr_csrwdata = data;
        tick();
        wb_wr_csrreg   = 1'b0;
    endtask

    // Every observed redirect must match the oldest expected target.
    always @(negedge clk) begin
        if (redirect_valid === 1'b1) begin
            if (exp_redir_q.size() == 0) begin
                check("unexpected_redirect", 32'd1, 32'd0);
            end else begin
                check("redirect_pc", redirect_pc, exp_redir_q.pop_front());
                check("redirect_interrupt", 32'(interrupt), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        cpurst = 1'b1;
        wb_wr_reg = 0; wb_wr_regindex = 0; wb_wr_wdata = 0; wb_pc = 0; wb_exp = 0;
        wb_wr_csrreg = 0; wb_wr_csrindex = 0; wb_wr_csrwdata = 0; wb_mret = 0; ext_irq = 0;
        csr_rindex = 0;
        repeat (3) tick();
        cpurst = 1'b0;
        tick();

        // reset state
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_interrupt", 32'(interrupt), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        csr_check("rst_mtvec", 12'h305, 32'h0);
        csr_check("rst_mstatus", 12'h300, 32'h0);
        csr_check("rst_mepc", 12'h341, 32'h0);
        csr_check("rst_mcause", 12'h342, 32'h0);

        // GPR pass-through and x0 suppression
        wb_wr_reg = 1; wb_wr_regindex = 5; wb_wr_wdata = 32'h1234;
        #0.5;
        check("rf_we", 32'(rf_we), 32'd1);
        check("rf_waddr", 32'(rf_waddr), 32'd5);
        check("rf_wdata", rf_wdata, 32'h1234);
        wb_wr_regindex = 0;
        #0.5;
        check("rf_we_x0", 32'(rf_we), 32'd0);
        wb_wr_reg = 0;

        // mtvec alignment, then exception
        csr_write(12'h305, 32'h103);
        csr_check("mtvec_aligned", 12'h305, 32'h100);
        wb_exp = 1; wb_pc = 32'h80; wb_wr_reg = 1; wb_wr_regindex = 3;
        #0.5;
        check("rf_we_exc", 32'(rf_we), 32'd0);
        exp_redir_q.push_back(32'h100);
        tick();
        wb_exp = 0; wb_wr_regindex = 7;
        #0.5;
        check("rf_we_in_trap", 32'(rf_we), 32'd0);
        wb_wr_reg = 0;
        csr_check("exc_mepc", 12'h341, 32'h80);
        csr_check("exc_mcause", 12'h342, 32'h2);
        csr_check("exc_mstatus", 12'h300, 32'h0);
        tick();
        check("exc_back_to_run", 32'(redirect_valid), 32'd0);

        // mstatus masking
        csr_write(12'h300, 32'hFFFF_FFFF);
        csr_check("mstatus_mask", 12'h300, 32'h88);
        csr_write(12'h300, 32'h8);
        csr_check("mstatus_mie", 12'h300, 32'h8);

        // external interrupt suppresses the GPR write
        ext_irq = 1; wb_pc = 32'h40; wb_wr_reg = 1; wb_wr_regindex = 9;
        #0.5;
        check("rf_we_irq", 32'(rf_we), 32'd0);
        exp_redir_q.push_back(32'h100);
        tick();
        ext_irq = 0; wb_wr_reg = 0;
        csr_check("irq_mcause", 12'h342, 32'h8000_000B);
        csr_check("irq_mepc", 12'h341, 32'h40);
        csr_check("irq_mstatus", 12'h300, 32'h80);
        tick();

        // mret keeps its GPR write but outranks a CSR write
        wb_mret = 1; wb_wr_reg = 1; wb_wr_regindex = 4;
        wb_wr_csrreg = 1; wb_wr_csrindex = 12'h340; wb_wr_csrwdata = 32'h55;
        #0.5;
        check("rf_we_mret", 32'(rf_we), 32'd1);
        exp_redir_q.push_back(32'h40);
        tick();
        wb_mret = 0; wb_wr_reg = 0; wb_wr_csrreg = 0;
        csr_check("mret_mstatus", 12'h300, 32'h88);
        csr_check("mret_mscratch", 12'h340, 32'h0);
        tick();

        // ext_irq with MIE=0 is ignored until MIE is set
        csr_write(12'h300, 32'h0);
        ext_irq = 1;
        repeat (3) tick();
        csr_write(12'h300, 32'h8);
        wb_pc = 32'h200;
        exp_redir_q.push_back(32'h100);
        tick();
        ext_irq = 0;
        csr_check("late_irq_mepc", 12'h341, 32'h200);
        tick();

        // exception outranks CSR write; reset during TRAP kills the redirect
        wb_exp = 1; wb_pc = 32'h300;
        wb_wr_csrreg = 1; wb_wr_csrindex = 12'h340; wb_wr_csrwdata = 32'hFF;
        tick();
        wb_exp = 0; wb_wr_csrreg = 0;
        csr_check("exc_mscratch", 12'h340, 32'h0);
        cpurst = 1'b1;
        #0.5;
        check("rst_trap_redirect", 32'(redirect_valid), 32'd0);
        check("rst_trap_interrupt", 32'(interrupt), 32'd0);
        csr_check("rst_trap_mtvec", 12'h305, 32'h0);
        tick();
        cpurst = 1'b0;
        tick();

        csr_check("unimpl_csr", 12'h123, 32'h0);
`ifdef WB_MCYCLE_EN
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'hB80, 32'h0);
        csr_check("mcycle_lo_load", 12'hB00, 32'hFFFF_FFFF);
        csr_check("mcycle_hi_load", 12'hB80, 32'h0);
        repeat (2) tick();
        csr_check("mcycle_hi_wrap", 12'hB80, 32'h1);
        csr_check("mcycle_lo_wrap", 12'hB00, 32'h1);
`else
        csr_check("mcycle_absent_lo", 12'hB00, 32'h0);
        csr_check("mcycle_absent_hi", 12'hB80, 32'h0);
`endif

        repeat (3) tick();
        check("redirects_outstanding", 32'(exp_redir_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
